fetch_pc_unit: RTL

//  Fetch-stage PC owner: holds the PC, runs the single-outstanding imem req/ack handshake,
//  and presents instr_F/pc_plus_F to the jump controller and the IF/ID register.

---
 rtl/fetch_pc_pkg.sv | 17 +
 rtl/fetch_pc_unit_pc_next_sel.sv | 27 ++
 rtl/fetch_pc_unit.sv | 107 ++++++++++
 3 files changed

// File: rtl/fetch_pc_pkg.sv
// Shared types and constants for the fetch-stage PC unit.
package fetch_pc_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP      = 32'd4;

  typedef enum logic [1:0] {
    FS_BOOT  = 2'd0,
    FS_FETCH = 2'd1,
    FS_HOLD  = 2'd2
  } fetch_state_e;

  function automatic logic [31:0] pc_inc(input logic [31:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/fetch_pc_unit_pc_next_sel.sv
// Next-PC priority mux: pending redirect, then branch,
// then jump, then sequential.
module pc_next_sel
  import fetch_pc_pkg::*;
(
  input  logic        redir_pend_i,
  input  logic [31:0] redir_pc_i,
  input  logic        branch_taken_i,
  input  logic [31:0] pc_branch_i,
  input  logic        jump_i,
  input  logic [31:0] pc_jump_i,
  input  logic [31:0] pc_plus_i,
  output logic [31:0] next_pc_o
);

  always_comb begin
    next_pc_o = pc_plus_i;
    if (redir_pend_i) begin
      next_pc_o = redir_pc_i;
    end else if (branch_taken_i) begin
      next_pc_o = pc_branch_i;
    end else if (jump_i) begin
      next_pc_o = pc_jump_i;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch-stage PC owner: single-outstanding imem handshake,
// delay-slot-preserving redirects, and the F-stage outputs.
module fetch_pc_unit
  import fetch_pc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_F,
  input  logic [31:0] pc_jump_F,
  input  logic        jump_stall,
  input  logic        stall_D,
  input  logic        branch_taken_D,
  input  logic [31:0] pc_branch_D,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_F,
  output logic [31:0] pc_plus_F,
  output logic [31:0] instr_F,
  output logic        valid_F
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic         redir_pend_q, redir_pend_d;
  logic [31:0]  redir_pc_q, redir_pc_d;
  logic [31:0]  next_pc;
  logic         adv;

  assign pc_F      = pc_q;
  assign pc_plus_F = pc_inc(pc_q);
  assign imem_addr = pc_q;

  pc_next_sel u_next_sel (
    .redir_pend_i   (redir_pend_q),
    .redir_pc_i     (redir_pc_q),
    .branch_taken_i (branch_taken_D),
    .pc_branch_i    (pc_branch_D),
    .jump_i         (jump_F),
    .pc_jump_i      (pc_jump_F),
    .pc_plus_i      (pc_plus_F),
    .next_pc_o      (next_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= FS_BOOT;
      pc_q         <= RESET_PC;
      instr_q      <= '0;
      redir_pend_q <= 1'b0;
      redir_pc_q   <= '0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      redir_pend_q <= redir_pend_d;
      redir_pc_q   <= redir_pc_d;
    end
  end

  always_comb begin
    imem_req     = 1'b0;
    valid_F      = 1'b0;
    instr_F      = instr_q;
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    redir_pend_d = redir_pend_q;
    redir_pc_d   = redir_pc_q;

    unique case (state_q)
      FS_BOOT: state_d = FS_FETCH;
      FS_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          valid_F = 1'b1;
          instr_F = imem_rdata;
        end
      end
      FS_HOLD: valid_F = 1'b1;
      default: state_d = FS_BOOT;
    endcase

    adv = valid_F & ~stall_D & ~jump_stall;

    if (adv) begin
      pc_d         = next_pc;
      state_d      = FS_FETCH;
      redir_pend_d = 1'b0;
    end else if (state_q == FS_FETCH && imem_ack) begin
      // Park the word so later bus activity cannot disturb it
      instr_d = imem_rdata;
      state_d = FS_HOLD;
    end

    // Delay slot not yet fetched: remember the branch target
    if (branch_taken_D && !stall_D && !adv) begin
      redir_pend_d = 1'b1;
      redir_pc_d   = pc_branch_D;
    end
  end

endmodule
